// File: rtl/reg_file_pkg.sv
// Shared definitions for the reg_file_sb register file slice: default
// geometry, the hardwired-zero register address and the clear FSM states.
package reg_file_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 6;
    localparam int ZERO_ADDR      = 0;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_e;

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// rf_scoreboard: one busy bit per register. Issue reserves a destination,
// either write-back port releases it, and a reservation arriving in the
// same cycle as a write-back to the same register wins. The rd_ok lookup
// treats a register being written this cycle as valid (forwarded).
// Enables arriving here are already qualified by the top (ready, zero reg).
module rf_scoreboard
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     wb0_en,
    input  logic [ADDR_W-1:0]        wb0_addr,
    input  logic                     wb1_en,
    input  logic [ADDR_W-1:0]        wb1_addr,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD-1:0]        rd_ok
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Next busy vector: write-backs release, then issue reserves so it wins.
    always_comb begin
        busy_d = busy_q;
        if (wb0_en) busy_d[wb0_addr] = 1'b0;
        if (wb1_en) busy_d[wb1_addr] = 1'b0;
        if (iss_en) busy_d[iss_addr] = 1'b1;
    end

    // Busy bits clear on reset and otherwise follow the next-state vector.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_ok
        logic [ADDR_W-1:0] addr;
        assign addr     = ra[k*ADDR_W +: ADDR_W];
        assign rd_ok[k] = !busy_q[addr]
                        || (wb0_en && (wb0_addr == addr))
                        || (wb1_en && (wb1_addr == addr));
    end

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register file with NUM_RD combinational read
// ports, two write-back ports with write-to-read forwarding, a per-register
// busy scoreboard and a post-reset sequencer that zeroes the storage.
// Optional feature macro: REG_FILE_ZERO_REG_EN (register 0 hardwired to 0).
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    output logic                     ready,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     wb0_en,
    input  logic [ADDR_W-1:0]        wb0_addr,
    input  logic [DATA_W-1:0]        wb0_data,
    input  logic                     wb1_en,
    input  logic [ADDR_W-1:0]        wb1_addr,
    input  logic [DATA_W-1:0]        wb1_data,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    output logic [NUM_RD-1:0]        rd_ok
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    rf_state_e         state_q;
    logic [ADDR_W-1:0] clrPtr_q;
    logic [DATA_W-1:0] ram_q [DEPTH];

    logic              issEff;
    logic              wb0Eff;
    logic              wb1Eff;
    logic [NUM_RD-1:0] sbOk;

    assign ready = (state_q == RUN);

`ifdef REG_FILE_ZERO_REG_EN
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_ADDR);
    assign issEff = ready && iss_en && (iss_addr != ZERO_A);
    assign wb0Eff = ready && wb0_en && (wb0_addr != ZERO_A);
    assign wb1Eff = ready && wb1_en && (wb1_addr != ZERO_A);
`else
    assign issEff = ready && iss_en;
    assign wb0Eff = ready && wb0_en;
    assign wb1Eff = ready && wb1_en;
`endif

    // Clear sequencer: walk every address once after reset, then stay in RUN.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= CLEAR;
            clrPtr_q <= '0;
        end else begin
            case (state_q)
                CLEAR: begin
                    clrPtr_q <= clrPtr_q + 1'b1;
                    if (clrPtr_q == LAST_ADDR) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    state_q <= RUN;
                end
                default: begin
                    state_q <= CLEAR;
                end
            endcase
        end
    end

    // Storage has no reset: zeroed by the sequencer, then written by wb1 last so it wins.
    always_ff @(posedge clk) begin
        if (!ready) begin
            ram_q[clrPtr_q] <= '0;
        end else begin
            if (wb0Eff) ram_q[wb0_addr] <= wb0_data;
            if (wb1Eff) ram_q[wb1_addr] <= wb1_data;
        end
    end

    rf_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD)
    ) u_scoreboard (
        .clk      (clk),
        .rstn     (rstn),
        .iss_en   (issEff),
        .iss_addr (iss_addr),
        .wb0_en   (wb0Eff),
        .wb0_addr (wb0_addr),
        .wb1_en   (wb1Eff),
        .wb1_addr (wb1_addr),
        .ra       (ra),
        .rd_ok    (sbOk)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] word;

        assign addr = ra[k*ADDR_W +: ADDR_W];

        // Read mux: stored word, overridden by wb0 then wb1 when writing this address.
        always_comb begin
            word = ram_q[addr];
            if (wb0Eff && (wb0_addr == addr)) word = wb0_data;
            if (wb1Eff && (wb1_addr == addr)) word = wb1_data;
        end

`ifdef REG_FILE_ZERO_REG_EN
        assign rd[k*DATA_W +: DATA_W] = (ready && (addr != ZERO_A)) ? word : '0;
        assign rd_ok[k]               = ready && ((addr == ZERO_A) || sbOk[k]);
`else
        assign rd[k*DATA_W +: DATA_W] = ready ? word : '0;
        assign rd_ok[k]               = ready && sbOk[k];
`endif
    end

endmodule
